// File: rtl/clk_div_monitor.sv
// Divided-clock checker: measures period and high time of a divided clock
// in source-clock cycles and reports lock, mismatch and loss-of-clock.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_div_clk,
  input  logic [CNT_W-1:0] i_ratio,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_lock,
  output logic             o_err,
  output logic             o_timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MEAS = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_MAX - CNT_W'(1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);

  logic [1:0]       sync;
  logic             s;
  logic             s_d;
  logic             rise;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcnt;
  logic [3:0]       mcnt;
  logic [CNT_W-1:0] half_lo;
  logic [CNT_W-1:0] half_hi;
  logic             match;

  assign s    = sync[1];
  assign rise = s & ~s_d;

  // Odd ratios give an off-by-half duty, so floor and ceil both pass.
  assign half_lo = i_ratio >> 1;
  assign half_hi = half_lo + CNT_W'(i_ratio[0]);
  assign match   = (cnt == i_ratio)
                && (i_ratio >= CNT_W'(2))
                && ((hcnt == half_lo) || (hcnt == half_hi));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[0], i_div_clk};
      s_d  <= s;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      mcnt      <= '0;
      o_period  <= '0;
      o_high    <= '0;
      o_valid   <= 1'b0;
      o_lock    <= 1'b0;
      o_err     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      o_lock  <= (mcnt == LOCK_N);
      case (state)
        IDLE: begin
          if (rise) begin
            cnt       <= CNT_W'(1);
            hcnt      <= CNT_W'(1);
            o_timeout <= 1'b0;
            state     <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            o_period  <= cnt;
            o_high    <= hcnt;
            o_valid   <= 1'b1;
            cnt       <= CNT_W'(1);
            hcnt      <= CNT_W'(1);
            o_timeout <= 1'b0;
            if (match) begin
              if (mcnt != LOCK_N)
                mcnt <= mcnt + 4'd1;
            end else begin
              mcnt  <= '0;
              o_err <= 1'b1;
            end
          end else if (cnt == CNT_LIM) begin
            // Counter parks at all-ones; the lost clock re-arms from IDLE.
            cnt       <= CNT_MAX;
            o_timeout <= 1'b1;
            mcnt      <= '0;
            o_lock    <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            hcnt <= hcnt + CNT_W'(s);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a behavioural divider drives the
// monitored clock with programmable period, duty and one-shot short period.
module tb_clk_div_monitor;

  logic       clk;
  logic       rst;
  logic       div_clk;
  logic [7:0] ratio;
  logic [7:0] period;
  logic [7:0] high;
  logic       valid;
  logic       lock;
  logic       err;
  logic       timeout;

  int vectors = 0;
  int errs    = 0;

  int per = 5;
  int hi  = 3;
  int cur_per = 5;
  int cur_hi  = 3;
  int ph  = 0;
  bit run = 0;
  bit inj = 0;

  clk_div_monitor #(.CNT_W(8), .LOCK_CNT(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_div_clk (div_clk),
    .i_ratio   (ratio),
    .o_period  (period),
    .o_high    (high),
    .o_valid   (valid),
    .o_lock    (lock),
    .o_err     (err),
    .o_timeout (timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    div_clk = 0;
    forever begin
      @(negedge clk);
      if (!run) begin
        div_clk = 0;
        ph = 0;
      end else begin
        if (ph == 0) begin
          if (inj) begin
            cur_per = 4;
            cur_hi  = 2;
            inj     = 0;
          end else begin
            cur_per = per;
            cur_hi  = hi;
          end
        end
        div_clk = (ph < cur_hi);
        ph = (ph + 1 >= cur_per) ? 0 : ph + 1;
      end
    end
  end

  task automatic wait_valid(input int lim, output bit got, output int n);
    got = 0;
    n = 0;
    while (!got && n < lim) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) got = 1;
    end
  endtask

  task automatic test_reset;
    bit got;
    int n;
    rst = 1;
    run = 0;
    ratio = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({period, high} !== 16'h0) begin
      errs++;
      $display("FAIL reset_data: got %h/%h expected 0/0", period, high);
    end
    vectors++;
    if ({valid, lock, err, timeout} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_flags: got %b expected 0000",
               {valid, lock, err, timeout});
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_lock;
    bit got;
    int n;
    @(posedge clk);
    #1;
    run = 1;
    for (int v = 1; v <= 6; v++) begin
      wait_valid(30, got, n);
      vectors++;
      if (!got) begin
        errs++;
        $display("FAIL lock_valid%0d: got timeout expected o_valid", v);
      end
      if (v == 1) begin
        vectors++;
        if (n < 6) begin
          errs++;
          $display("FAIL first_rise_arms: got %0d cycles expected >=6", n);
        end
      end
      vectors++;
      if (period !== 8'd5 || !(high == 8'd2 || high == 8'd3) || err !== 1'b0) begin
        errs++;
        $display("FAIL lock_meas%0d: got p=%0d h=%0d e=%b expected p=5 h=2|3 e=0",
                 v, period, high, err);
      end
      @(posedge clk);
      #1;
      if (v == 3) begin
        vectors++;
        if (lock !== 1'b0) begin
          errs++;
          $display("FAIL lock_early: got %b expected 0", lock);
        end
      end
      if (v >= 4) begin
        vectors++;
        if (lock !== 1'b1) begin
          errs++;
          $display("FAIL lock_set%0d: got %b expected 1", v, lock);
        end
      end
    end
  endtask

  task automatic test_ratio_change;
    bit got;
    int n;
    ratio = 8'd7;
    wait_valid(30, got, n);
    vectors++;
    if (!got || err !== 1'b1 || period !== 8'd5) begin
      errs++;
      $display("FAIL ratio_err: got v=%b e=%b p=%0d expected v=1 e=1 p=5",
               got, err, period);
    end
    vectors++;
    if (lock !== 1'b1) begin
      errs++;
      $display("FAIL ratio_lock_hold: got %b expected 1", lock);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (lock !== 1'b0) begin
      errs++;
      $display("FAIL ratio_lock_drop: got %b expected 0", lock);
    end
    ratio = 8'd5;
    for (int v = 1; v <= 4; v++) begin
      wait_valid(30, got, n);
      @(posedge clk);
      #1;
      vectors++;
      if (!got || lock !== (v == 4)) begin
        errs++;
        $display("FAIL relock%0d: got v=%b l=%b expected v=1 l=%b",
                 v, got, lock, v == 4);
      end
    end
  endtask

  task automatic test_timeout;
    bit got;
    bit saw;
    bit cleared;
    int n;
    int first;
    bit lk;
    bit lk253;
    wait_valid(30, got, n);
    run = 0;
    first = 0;
    lk = 1;
    lk253 = 0;
    for (int k = 1; k <= 300 && first == 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 253) lk253 = lock;
      if (timeout) begin
        first = k;
        lk = lock;
      end
    end
    vectors++;
    if (first != 254) begin
      errs++;
      $display("FAIL timeout_time: got %0d expected 254", first);
    end
    vectors++;
    if (lk !== 1'b0 || lk253 !== 1'b1) begin
      errs++;
      $display("FAIL timeout_lock: got %b/%b expected 1/0", lk253, lk);
    end
    run = 1;
    saw = 0;
    cleared = 0;
    for (int k = 0; k < 30 && !cleared; k++) begin
      @(posedge clk);
      #1;
      if (valid) saw = 1;
      if (!timeout) cleared = 1;
    end
    vectors++;
    if (!cleared || saw) begin
      errs++;
      $display("FAIL timeout_clear: got clr=%b valid=%b expected 1/0",
               cleared, saw);
    end
    wait_valid(30, got, n);
    vectors++;
    if (!got || period !== 8'd5 || timeout !== 1'b0) begin
      errs++;
      $display("FAIL resume_valid: got v=%b p=%0d t=%b expected 1/5/0",
               got, period, timeout);
    end
  endtask

  task automatic test_glitch;
    bit got;
    bit found;
    int n;
    for (int v = 0; v < 8 && !lock; v++) begin
      wait_valid(30, got, n);
      @(posedge clk);
      #1;
    end
    vectors++;
    if (lock !== 1'b1) begin
      errs++;
      $display("FAIL glitch_prelock: got %b expected 1", lock);
    end
    inj = 1;
    found = 0;
    for (int v = 0; v < 3 && !found; v++) begin
      wait_valid(30, got, n);
      if (got && err) found = 1;
    end
    vectors++;
    if (!found || period !== 8'd4 || high !== 8'd2) begin
      errs++;
      $display("FAIL glitch_err: got f=%b p=%0d h=%0d expected 1/4/2",
               found, period, high);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (lock !== 1'b0) begin
      errs++;
      $display("FAIL glitch_lock_drop: got %b expected 0", lock);
    end
    for (int v = 1; v <= 4; v++) begin
      wait_valid(30, got, n);
      vectors++;
      if (!got || err !== 1'b0 || period !== 8'd5) begin
        errs++;
        $display("FAIL glitch_good%0d: got v=%b e=%b p=%0d expected 1/0/5",
                 v, got, err, period);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (lock !== (v == 4)) begin
        errs++;
        $display("FAIL glitch_relock%0d: got %b expected %b", v, lock, v == 4);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    bit prev;
    int n;
    int edges;
    wait_valid(30, got, n);
    @(posedge clk);
    @(posedge clk);
    #1;
    vectors++;
    if (lock !== 1'b1) begin
      errs++;
      $display("FAIL midrst_prelock: got %b expected 1", lock);
    end
    rst = 1;
    #1;
    vectors++;
    if ({period, high} !== 16'h0 || {valid, lock, err, timeout} !== 4'b0) begin
      errs++;
      $display("FAIL midrst_async: got %h/%h %b expected 0/0 0000",
               period, high, {valid, lock, err, timeout});
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 10 && div_clk; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 0;
    prev = div_clk;
    edges = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      #1;
      if (div_clk && !prev) edges++;
      prev = div_clk;
      if (valid) got = 1;
    end
    vectors++;
    if (!got || edges != 2 || period !== 8'd5) begin
      errs++;
      $display("FAIL midrst_first: got v=%b edges=%0d p=%0d expected 1/2/5",
               got, edges, period);
    end
  endtask

  task automatic test_bad_ratio;
    bit got;
    int n;
    ratio = 8'd1;
    per = 3;
    hi = 2;
    for (int v = 1; v <= 5; v++) begin
      wait_valid(30, got, n);
      vectors++;
      if (!got || err !== 1'b1) begin
        errs++;
        $display("FAIL ratio1_err%0d: got v=%b e=%b expected 1/1", v, got, err);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (lock !== 1'b0) begin
        errs++;
        $display("FAIL ratio1_lock%0d: got %b expected 0", v, lock);
      end
    end
    vectors++;
    if (period !== 8'd3) begin
      errs++;
      $display("FAIL ratio1_period: got %0d expected 3", period);
    end
  endtask

  initial begin
    rst = 1;
    ratio = 8'd5;
    test_reset;
    test_lock;
    test_ratio_change;
    test_timeout;
    test_glitch;
    test_reset_mid;
    test_bad_ratio;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
